maxpool2x2_stream: RTL
======================

Name: maxpool2x2_stream

Overview:
- 2x2 stride-2 max-pooling stage placed directly downstream of cnn_accel.
- Consumes the accelerator's raster-order out_pixel/out_valid stream: 4 channels x 8-bit, packed into 32 bits, channel 0 in [7:0].
- Emits a pooled stream of the same packing at half width and half height, which feeds bmp_image_writer instances or the next layer's input buffer.
- No backpressure. The input stream is pure valid-qualified, and so is the output.

Parameters:
- W_SIZE, 12, width of the width/height config fields (max 4K).
- N_CH, 4, channels packed per input word.
- W_PIX, 8, bits per channel (unsigned, post-ReLU).
- MAX_WIDTH, 128, maximum supported input line width; sets line-buffer depth to MAX_WIDTH/2.

Ports:
- HCLK  input  1  clock; all logic on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- i_width  input  W_SIZE  input frame width in pixels; sampled on i_start.
- i_height  input  W_SIZE  input frame height in lines; sampled on i_start.
- i_start  input  1  one-cycle pulse: latch i_width/i_height, clear counters and window state.
- i_pixel  input  N_CH*W_PIX  input pixel word (cnn_accel out_pixel).
- i_valid  input  1  input pixel qualifier (cnn_accel out_valid).
- o_pixel  output  N_CH*W_PIX  pooled pixel word.
- o_valid  output  1  pooled pixel qualifier; one-cycle pulse per output pixel.
- o_frame_done  output  1  one-cycle pulse after the last input pixel of a frame.

Behaviour:
- Reset: o_pixel=0, o_valid=0, o_frame_done=0; col/row counters, latched width/height, horizontal hold register and line buffer read data all 0. Line buffer contents need no reset.
- Counters:
  - col advances on each i_valid and wraps at width-1 while row increments.
  - row wraps at height-1 back to 0, so back-to-back frames need no new i_start.
- Horizontal step:
  - Even col: store i_pixel in the hold register.
  - Odd col: hmax = per-channel unsigned max(hold, i_pixel).
- Vertical step:
  - Even row, odd col: write hmax to linebuf[col>>1].
  - Odd row, odd col: o_pixel = per-channel max(linebuf[col>>1], hmax), and o_valid pulses.
- Latency: o_valid/o_pixel are registered 1 cycle after the i_valid beat that completes a 2x2 window. The line-buffer read address is col>>1 and is issued on the even-col beat, so an RTL with synchronous-read RAM meets the 1-cycle latency.
- Per-channel max:
  - Independent across channels.
  - Unsigned 8-bit compare.
  - Ties select either operand (values are equal).
- Odd dimensions:
  - Odd width: the last column of each line is consumed for counting but never pooled.
  - Odd height: the last line is consumed but produces no output.
  - Output size is floor(W/2) x floor(H/2).
- Width above MAX_WIDTH: columns >= MAX_WIDTH are counted but produce no line-buffer writes or outputs.
- Width < 2 or height < 2: no o_valid for the frame; o_frame_done still pulses.
- o_frame_done: registered 1 cycle after the i_valid beat at (col=W-1, row=H-1). For even W/H it is coincident with the final o_valid.
- i_start mid-frame: takes priority over a same-cycle i_valid, which is discarded.
  - Counters clear and the partial window is dropped.
  - No o_valid or o_frame_done is generated from the pre-start data.
  - Outputs already in flight (registered in the same cycle) still complete.
- Reset mid-frame: immediate return to reset values; the next frame requires i_start.
- i_valid gaps (cnn_accel HSYNC/start-up delays) are tolerated anywhere. State holds while i_valid=0, and o_valid stays 0.

Decomposition:
- Shared package cnn_pool_pkg holds N_CH, W_PIX, W_SIZE and a pixel-word typedef (N_CH*W_PIX bits); the cnn_accel wrapper uses the same package.
- Sub-module chmax_packed: combinational per-channel unsigned max of two packed words, instantiated twice (horizontal and vertical).
- Line buffer: an inferred single-port RAM inside the block, depth MAX_WIDTH/2, width N_CH*W_PIX.

Test Plan:
- Basic 4x4 frame: W=4, H=4, input pixel (r,c) with all channels = 16*r+c, continuous i_valid -> exactly 4 o_valid pulses with channel values 0x11, 0x13, 0x31, 0x33; o_frame_done coincident with the 4th pulse.
- Channel independence: 2x2 frame with inputs 0xFF000001, 0x01FF0000, 0x0001FF00, 0x000001FF -> single output 0xFFFFFFFF.
- Odd dimensions: W=5, H=3, all pixels 0x10203040 except (1,4)=0xFFFFFFFF -> 2 outputs, both 0x10203040; o_frame_done after the 15th input.
- Gapped stream: 128x128 frame with cnn_accel-style 160-cycle gaps between lines -> 4096 outputs matching a software maxpool model; each o_valid exactly 1 cycle after its completing input.
- Mid-frame restart: W=4, H=4, i_start asserted after 6 inputs, then a clean frame of all 0x55 -> exactly 4 outputs of 0x55555555; no output reflects pre-start data.
- Back-to-back frames plus reset: two 4x4 frames with no i_start between -> 8 outputs, 2 o_frame_done pulses; then HRESETn low mid-third-frame -> o_valid, o_pixel and o_frame_done are 0 immediately.

Source files
------------

// File: rtl/cnn_pool_pkg.sv
// Shared pixel-stream types for cnn_accel and its downstream pooling stages.
package cnn_pool_pkg;
    localparam int N_CH   = 4;
    localparam int W_PIX  = 8;
    localparam int W_SIZE = 12;

    typedef logic [N_CH*W_PIX-1:0]        pix_t;
    typedef logic [N_CH-1:0][W_PIX-1:0]   pix_lanes_t;
endpackage

// File: rtl/maxpool2x2_stream_chmax_packed.sv
// Per-channel unsigned max of two packed pixel words, purely combinational.
module chmax_packed
    import cnn_pool_pkg::*;
(
    input  pix_t a_i,
    input  pix_t b_i,
    output pix_t y_o
);
    pix_lanes_t a_l, b_l, y_l;

    assign a_l = a_i;
    assign b_l = b_i;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        assign y_l[g] = (a_l[g] > b_l[g]) ? a_l[g] : b_l[g];
    end

    assign y_o = y_l;
endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pool on a raster pixel stream; one half-width line buffer
// holds the horizontal maxima of each even row until the odd row completes.
module maxpool2x2_stream
    import cnn_pool_pkg::*;
#(
    parameter int MAX_WIDTH = 128
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [W_SIZE-1:0]      i_width,
    input  logic [W_SIZE-1:0]      i_height,
    input  logic                   i_start,
    input  logic [N_CH*W_PIX-1:0]  i_pixel,
    input  logic                   i_valid,
    output logic [N_CH*W_PIX-1:0]  o_pixel,
    output logic                   o_valid,
    output logic                   o_frame_done
);
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [W_SIZE-1:0] MAXW = W_SIZE'(MAX_WIDTH);

    logic [W_SIZE-1:0] width_q, width_d, height_q, height_d;
    logic [W_SIZE-1:0] col_q, col_d, row_q, row_d;
    logic              ok_q, ok_d;
    pix_t              hold_q, hold_d, rd_q, opix_q, opix_d;
    logic              ovld_q, ovld_d, done_q, done_d;
    logic              lb_we, lb_re, last_col, last_row, in_buf;
    logic [AW-1:0]     addr;
    pix_t              hmax, vmax;
    pix_t              lbuf [DEPTH];

    chmax_packed u_hmax (.a_i(hold_q), .b_i(i_pixel), .y_o(hmax));
    chmax_packed u_vmax (.a_i(rd_q),   .b_i(hmax),    .y_o(vmax));

    assign last_col = (col_q == width_q - W_SIZE'(1));
    assign last_row = (row_q == height_q - W_SIZE'(1));
    assign in_buf   = (col_q < MAXW);
    assign addr     = col_q[AW:1];

    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        ok_d     = ok_q;
        hold_d   = hold_q;
        opix_d   = opix_q;
        ovld_d   = 1'b0;
        done_d   = 1'b0;
        lb_we    = 1'b0;
        lb_re    = 1'b0;
        if (i_start) begin
            // Start wins over a same-cycle beat; that beat is dropped.
            width_d  = i_width;
            height_d = i_height;
            col_d    = '0;
            row_d    = '0;
            hold_d   = '0;
            ok_d     = (i_width >= W_SIZE'(2)) && (i_height >= W_SIZE'(2));
        end else if (i_valid) begin
            col_d  = last_col ? '0 : col_q + W_SIZE'(1);
            if (last_col)
                row_d = last_row ? '0 : row_q + W_SIZE'(1);
            done_d = last_col & last_row;
            if (!col_q[0]) begin
                // Even column: park pixel and prefetch the matching line-buffer word.
                hold_d = i_pixel;
                lb_re  = in_buf;
            end else if (in_buf && ok_q) begin
                if (!row_q[0]) begin
                    lb_we = 1'b1;
                end else begin
                    ovld_d = 1'b1;
                    opix_d = vmax;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ok_q     <= 1'b0;
            hold_q   <= '0;
            opix_q   <= '0;
            ovld_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ok_q     <= ok_d;
            hold_q   <= hold_d;
            opix_q   <= opix_d;
            ovld_q   <= ovld_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (lb_we)
            lbuf[addr] <= hmax;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            rd_q <= '0;
        else if (lb_re)
            rd_q <= lbuf[addr];
    end

    assign o_pixel      = opix_q;
    assign o_valid      = ovld_q;
    assign o_frame_done = done_q;
endmodule
